// File: rtl/block_data_memory_if.sv
// Data-cache <-> block memory request/response bundle: one block per request, MEMBUSY as the only flow control.
interface block_data_memory_if;
    logic        MEMREAD;
    logic        MEMWRITE;
    logic [5:0]  MEMADDRESS;
    logic [31:0] MEMWRITEDATA;
    logic [31:0] MEMREADDATA;
    logic        MEMBUSY;

    modport master (
        output MEMREAD, MEMWRITE, MEMADDRESS, MEMWRITEDATA,
        input  MEMREADDATA, MEMBUSY
    );

    modport slave (
        input  MEMREAD, MEMWRITE, MEMADDRESS, MEMWRITEDATA,
        output MEMREADDATA, MEMBUSY
    );
endinterface

// File: rtl/block_data_memory.sv
// 64 x 32-bit block store behind a fixed-latency IDLE/ACCESS/DONE sequencer; LATENCY+1 edges from accept to DONE.
// MEMBUSY is the only backpressure: high while a request is being accepted or serviced, low for the single DONE cycle.
module block_data_memory #(
    parameter int LATENCY = 5
) (
    input logic                  CLK,
    input logic                  RESET,
    block_data_memory_if.slave   bus
);
    localparam int CNT_W = $clog2(LATENCY) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              op_wr_q;
    logic [5:0]        addr_q;
    logic [31:0]       data_q;
    logic [31:0]       rdata_q;
    logic [31:0]       mem_q [64];
    logic              accept;
    logic              busy;

    assign accept = bus.MEMREAD | bus.MEMWRITE;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DONE always returns to IDLE so a held request costs one IDLE cycle before re-acceptance.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    busy    = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                busy = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q   <= '0;
            op_wr_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            rdata_q <= '0;
            for (int i = 0; i < 64; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cnt_q   <= '0;
                        op_wr_q <= bus.MEMWRITE;
                        addr_q  <= bus.MEMADDRESS;
                        data_q  <= bus.MEMWRITEDATA;
                    end
                end
                ACCESS: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST) begin
                        if (op_wr_q) begin
                            mem_q[addr_q] <= data_q;
                        end else begin
                            rdata_q <= mem_q[addr_q];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.MEMBUSY     = busy;
    assign bus.MEMREADDATA = rdata_q;
endmodule

// File: tb/tb_block_data_memory.sv
// Directed bench for block_data_memory at LATENCY=5: busy-window length, read/write data, priority, reset abort.
module tb_block_data_memory;
    logic CLK;
    logic RESET;
    int   checks;
    int   errors;

    block_data_memory_if bif ();

    block_data_memory #(.LATENCY(5)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bif.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drives a request for one edge, then measures the MEMBUSY window until the DONE cycle (returns inside DONE).
    // lead counts non-busy cycles before the window opens.
    task automatic do_req(input bit rd, input bit wr, input logic [5:0] a, input logic [31:0] d,
                          output int nbusy, output int lead, output bit done_ok);
        bif.MEMREAD      = rd;
        bif.MEMWRITE     = wr;
        bif.MEMADDRESS   = a;
        bif.MEMWRITEDATA = d;
        nbusy   = 0;
        lead    = 0;
        done_ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (bif.MEMBUSY) begin
                nbusy++;
            end else if (nbusy > 0) begin
                done_ok = 1'b1;
                break;
            end else begin
                lead++;
            end
            @(posedge CLK);
            #1;
            if (nbusy > 0) begin
                bif.MEMREAD  = 1'b0;
                bif.MEMWRITE = 1'b0;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic test_reset;
        bif.MEMREAD = 0; bif.MEMWRITE = 0; bif.MEMADDRESS = 0; bif.MEMWRITEDATA = 0;
        RESET = 1'b1;
        idle_cycles(2);
        RESET = 1'b0;
        #1;
        checks++;
        if (bif.MEMBUSY !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", bif.MEMBUSY);
        end
        checks++;
        if (bif.MEMREADDATA !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h expected 00000000", bif.MEMREADDATA);
        end
    endtask

    task automatic test_first_read;
        int nb, ld; bit ok;
        do_req(1, 0, 6'd9, 32'h0, nb, ld, ok);
        checks++;
        if (!ok || nb != 6) begin
            errors++; $display("FAIL first_read_busy: got %0d cycles (done=%0d) expected 6", nb, ok);
        end
        checks++;
        if (bif.MEMREADDATA !== 32'h0) begin
            errors++; $display("FAIL first_read_data: got %h expected 00000000", bif.MEMREADDATA);
        end
        idle_cycles(1);
    endtask

    task automatic test_write_read;
        int nb, ld; bit ok;
        do_req(0, 1, 6'd9, 32'hDEADBEEF, nb, ld, ok);
        checks++;
        if (!ok || nb != 6) begin
            errors++; $display("FAIL wr9_busy: got %0d cycles (done=%0d) expected 6", nb, ok);
        end
        idle_cycles(1);
        do_req(1, 0, 6'd9, 32'h0, nb, ld, ok);
        checks++;
        if (bif.MEMREADDATA !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rd9_data: got %h expected deadbeef", bif.MEMREADDATA);
        end
        idle_cycles(3);
        checks++;
        if (bif.MEMREADDATA !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rdata_hold: got %h expected deadbeef", bif.MEMREADDATA);
        end
        do_req(1, 0, 6'd10, 32'h0, nb, ld, ok);
        checks++;
        if (bif.MEMREADDATA !== 32'h0) begin
            errors++; $display("FAIL rd10_data: got %h expected 00000000", bif.MEMREADDATA);
        end
        idle_cycles(1);
    endtask

    task automatic test_write_priority;
        int nb, ld; bit ok;
        do_req(1, 0, 6'd9, 32'h0, nb, ld, ok);
        idle_cycles(1);
        do_req(1, 1, 6'd3, 32'h12345678, nb, ld, ok);
        checks++;
        if (bif.MEMREADDATA !== 32'hDEADBEEF) begin
            errors++; $display("FAIL prio_rdata_unchanged: got %h expected deadbeef", bif.MEMREADDATA);
        end
        idle_cycles(1);
        do_req(1, 0, 6'd3, 32'h0, nb, ld, ok);
        checks++;
        if (bif.MEMREADDATA !== 32'h12345678) begin
            errors++; $display("FAIL prio_rd3: got %h expected 12345678", bif.MEMREADDATA);
        end
        idle_cycles(1);
    endtask

    task automatic test_back_to_back;
        int nb1, ld1, nb2, ld2; bit ok1, ok2;
        do_req(0, 1, 6'd1, 32'hA5A5A5A5, nb1, ld1, ok1);
        do_req(1, 0, 6'd2, 32'h0, nb2, ld2, ok2);
        checks++;
        if (!ok1 || nb1 != 6) begin
            errors++; $display("FAIL b2b_write_busy: got %0d cycles expected 6", nb1);
        end
        checks++;
        if (!ok2 || nb2 != 6) begin
            errors++; $display("FAIL b2b_read_busy: got %0d cycles expected 6", nb2);
        end
        checks++;
        if (ld2 != 1) begin
            errors++; $display("FAIL b2b_gap: got %0d idle cycles before window expected 1", ld2);
        end
        checks++;
        if (bif.MEMREADDATA !== 32'h0) begin
            errors++; $display("FAIL b2b_rd2: got %h expected 00000000", bif.MEMREADDATA);
        end
        idle_cycles(1);
        do_req(1, 0, 6'd1, 32'h0, nb1, ld1, ok1);
        checks++;
        if (bif.MEMREADDATA !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL b2b_rd1: got %h expected a5a5a5a5", bif.MEMREADDATA);
        end
        idle_cycles(1);
    endtask

    task automatic test_reset_abort;
        int nb, ld; bit ok;
        bif.MEMREAD = 0; bif.MEMWRITE = 1; bif.MEMADDRESS = 6'd4; bif.MEMWRITEDATA = 32'hFFFFFFFF;
        idle_cycles(1);
        bif.MEMWRITE = 0;
        idle_cycles(2);
        RESET = 1'b1;
        idle_cycles(1);
        RESET = 1'b0;
        #1;
        checks++;
        if (bif.MEMBUSY !== 1'b0) begin
            errors++; $display("FAIL abort_busy: got %b expected 0", bif.MEMBUSY);
        end
        do_req(1, 0, 6'd4, 32'h0, nb, ld, ok);
        checks++;
        if (!ok || nb != 6 || bif.MEMREADDATA !== 32'h0) begin
            errors++; $display("FAIL abort_rd4: got %h busy %0d expected 00000000 busy 6", bif.MEMREADDATA, nb);
        end
        idle_cycles(1);
    endtask

    task automatic test_ignore_changes;
        int nb, ld; bit ok;
        bif.MEMREAD = 0; bif.MEMWRITE = 1; bif.MEMADDRESS = 6'd5; bif.MEMWRITEDATA = 32'h11;
        idle_cycles(1);
        bif.MEMADDRESS = 6'd6; bif.MEMWRITEDATA = 32'h22; bif.MEMREAD = 1; bif.MEMWRITE = 0;
        idle_cycles(2);
        bif.MEMREAD = 0;
        idle_cycles(6);
        do_req(1, 0, 6'd5, 32'h0, nb, ld, ok);
        checks++;
        if (bif.MEMREADDATA !== 32'h11) begin
            errors++; $display("FAIL ignore_blk5: got %h expected 00000011", bif.MEMREADDATA);
        end
        idle_cycles(1);
        do_req(1, 0, 6'd6, 32'h0, nb, ld, ok);
        checks++;
        if (bif.MEMREADDATA !== 32'h0) begin
            errors++; $display("FAIL ignore_blk6: got %h expected 00000000", bif.MEMREADDATA);
        end
        idle_cycles(1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        RESET  = 1'b0;
        #2;
        test_reset;
        test_first_read;
        test_write_read;
        test_write_priority;
        test_back_to_back;
        test_reset_abort;
        test_ignore_changes;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/block_data_memory.md
BLOCK_DATA_MEMORY -- requirements
Module: block_data_memory

Interface
REQ-001 SHALL have parameter: LATENCY, default 5, number of ACCESS-state cycles per request (legal range 1..15).
REQ-002 SHALL have port: CLK  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have port: RESET  input  1  reset, synchronous, active-high; clock CLK.
REQ-004 SHALL have port: MEMREAD  input  1  block-read request from data cache.
REQ-005 SHALL have port: MEMWRITE  input  1  block-write request from data cache.
REQ-006 SHALL have port: MEMADDRESS  input  6  block address {tag,index}.
REQ-007 SHALL have port: MEMWRITEDATA  input  32  block to write; byte 0 in bits [7:0].
REQ-008 SHALL have port: MEMREADDATA  output  32  registered block read result.
REQ-009 SHALL have port: MEMBUSY  output  1  request accepted/in progress; low = result ready / idle.

Function
REQ-010 SHALL hold 64 blocks x 32 bits of storage, indexed by MEMADDRESS.
REQ-011 SHALL implement FSM states IDLE, ACCESS, DONE, plus a cycle counter of width ceil(log2(LATENCY))+1.
REQ-012 SHALL drive MEMBUSY combinationally: 1 when (IDLE and (MEMREAD or MEMWRITE)) or ACCESS; 0 in DONE and in IDLE with no request.
REQ-013 IDLE -> ACCESS at an edge where MEMREAD or MEMWRITE is high; at that edge capture address, write data and operation, and clear counter to 0.
REQ-014 SHALL give MEMWRITE priority when MEMREAD and MEMWRITE are high at the capture edge (operation = write).
REQ-015 ACCESS: counter increments each edge; at the edge where counter == LATENCY-1, perform the captured operation and go to DONE.
REQ-016 Write SHALL update the addressed block with the captured data; MEMREADDATA unchanged.
REQ-017 Read SHALL load MEMREADDATA with the addressed block at the ACCESS->DONE edge.
REQ-018 DONE -> IDLE unconditionally at the next edge; a request still high at that edge SHALL NOT start a new access.
REQ-019 From request-assert edge to DONE entry: LATENCY+1 edges; MEMBUSY low for exactly one cycle (DONE) per completed request.
REQ-020 Changes on MEMADDRESS, MEMWRITEDATA, MEMREAD, MEMWRITE during ACCESS or DONE SHALL be ignored; request deassert mid-ACCESS does not abort.
REQ-021 MEMREADDATA SHALL hold its value until the next completed read or reset.
REQ-022 Back-to-back requests (write-back then refill): a request present in IDLE after DONE SHALL be accepted at that edge, so minimum spacing = one IDLE cycle between DONE and the next ACCESS.

Reset
REQ-023 At a rising edge with RESET high: state = IDLE, counter = 0, MEMREADDATA = 32'h0, all 64 blocks = 32'h0.
REQ-024 RESET SHALL take priority over every transition, including mid-ACCESS and DONE; an aborted write SHALL NOT modify storage.
REQ-025 MEMBUSY SHALL follow REQ-012 after reset (0 unless a request is present).

Verification
REQ-026 After reset, MEMREAD=1, MEMADDRESS=6'd9, LATENCY=5 -> MEMBUSY high for 6 cycles, low in DONE with MEMREADDATA=32'h0.
REQ-027 Write 32'hDEADBEEF to 6'd9, then read 6'd9 -> after read's DONE MEMREADDATA=32'hDEADBEEF; other blocks read 0.
REQ-028 MEMREAD and MEMWRITE both high, address 6'd3, data 32'h12345678 -> treated as write; a later read of 6'd3 returns 32'h12345678, MEMREADDATA unchanged at write completion.
REQ-029 Write 6'd1 = 32'hA5A5A5A5 immediately followed by read 6'd2 (cache write-back/refill pattern) -> two full 6-cycle MEMBUSY windows separated by DONE+IDLE; read returns 32'h0.
REQ-030 RESET asserted at ACCESS counter = 2 of a write to 6'd4 = 32'hFFFFFFFF -> next cycle IDLE, MEMBUSY 0, later read of 6'd4 returns 32'h0.
REQ-031 Address/data changed from 6'd5 to 6'd6 mid-ACCESS of a write 32'h11 -> block 5 = 32'h11, block 6 = 32'h0.
